// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: turns one core load/store into one or two word-aligned
// memory accesses with byte enables, then returns a single extended completion.
module lsu_mem_initiator #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a posedge with req_valid && req_ready;
  // req_ready is high only in IDLE, so at most one request is ever in flight.
  // mem_req holds all mem_* fields stable until the cycle mem_ack is seen high.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC0 = 2'd1,
    S_ACC1 = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam bit                CNT_EN  = (ACK_TIMEOUT != 0);
  localparam int                CNT_W   = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(ACK_TIMEOUT);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0]        off;
  logic [3:0]        size_mask;
  logic [7:0]        lane_mask;
  logic [31:0]       wdata_sized;
  logic [63:0]       lane_data;
  logic              split;
  logic [31:0]       word0_addr;
  logic [31:0]       word1_addr;
  logic [31:0]       load_shift;
  logic [31:0]       load_data;

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = !we;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte-lane placement over an 8-byte window spanning word0 and word1.
  always_comb begin
    off = addr_q[1:0];
    case (funct3_q[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    case (funct3_q[1:0])
      2'b00:   wdata_sized = {24'h0, wdata_q[7:0]};
      2'b01:   wdata_sized = {16'h0, wdata_q[15:0]};
      default: wdata_sized = wdata_q;
    endcase
    lane_mask  = {4'h0, size_mask} << off;
    lane_data  = {32'h0, wdata_sized} << {off, 3'b000};
    split      = |lane_mask[7:4];
    word0_addr = {addr_q[31:2], 2'b00};
    word1_addr = word0_addr + 32'd4;
  end

  // rdata1_q is cleared on accept, so a non-split load sees zeros above.
  always_comb begin
    load_shift = 32'({rdata1_q, rdata0_q} >> {off, 3'b000});
    case (funct3_q)
      3'b000:  load_data = {{24{load_shift[7]}}, load_shift[7:0]};
      3'b001:  load_data = {{16{load_shift[15]}}, load_shift[15:0]};
      3'b010:  load_data = load_shift;
      3'b100:  load_data = {24'h0, load_shift[7:0]};
      3'b101:  load_data = {16'h0, load_shift[15:0]};
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'h0;
    mem_be     = 4'h0;
    mem_wdata  = 32'h0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata0_d = 32'h0;
          rdata1_d = 32'h0;
          cnt_d    = '0;
          err_d    = !funct3_legal(req_we, req_funct3);
          state_d  = funct3_legal(req_we, req_funct3) ? S_ACC0 : S_RESP;
        end
      end

      S_ACC0: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = word0_addr;
        mem_be    = lane_mask[3:0];
        mem_wdata = lane_data[31:0];
        if (mem_ack) begin
          rdata0_d = mem_rdata;
          cnt_d    = '0;
          state_d  = split ? S_ACC1 : S_RESP;
        end else if (CNT_EN && (cnt_q == CNT_MAX)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ACC1: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = word1_addr;
        mem_be    = lane_mask[7:4];
        mem_wdata = lane_data[63:32];
        if (mem_ack) begin
          rdata1_d = mem_rdata;
          state_d  = S_RESP;
        end else if (CNT_EN && (cnt_q == CNT_MAX)) begin
          // The first half of a split store has already landed; it stays.
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (!we_q && !err_q) ? load_data : 32'h0;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: byte-level reference model feeding expected
// memory accesses and completions to a responder and a response monitor.
module tb_lsu_mem_initiator;

  localparam int unsigned TO    = 4;
  localparam int          NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [1:0]  dbg_state;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // {resp_edge[31:0], err, rdata[31:0]}
  logic [64:0] exp_q[$];
  // {we, addr[31:0], be[3:0], wdata[31:0]}
  logic [68:0] exp_acc_q[$];
  int          dly_q[$];

  logic [31:0] bus_mem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];

  lsu_mem_initiator #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] wa);
    return bus_mem.exists(wa) ? bus_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] ba);
    logic [31:0] w;
    if (ref_mem.exists(ba)) return ref_mem[ba];
    w = init_word({ba[31:2], 2'b00});
    return w[8*int'(ba[1:0]) +: 8];
  endfunction

  task automatic preload(input logic [31:0] wa, input logic [31:0] v);
    bus_mem[wa] = v;
    for (int i = 0; i < 4; i++) ref_mem[wa + 32'(i)] = v[8*i +: 8];
  endtask

  // ---------------- driver + reference model ----------------
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int d0, input int d1,
                       input bit expect_resp);
    int          n, waited, nacc, dur, k, d;
    bit          legal, err;
    logic [31:0] wa [2];
    logic [3:0]  be [2];
    logic [31:0] wd [2];
    logic [31:0] b, val, rdata;
    int unsigned t;

    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    waited = 0;
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 80'(req_ready), 80'(1));
      req_valid = 1'b0;
      return;
    end
    t = cyc + 1;

    legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
            (!we && (f3 == 3'b100 || f3 == 3'b101));
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;

    wa[0] = {addr[31:2], 2'b00};
    wa[1] = wa[0] + 32'd4;
    for (int j = 0; j < 2; j++) begin
      be[j] = 4'h0;
      wd[j] = 32'h0;
    end
    for (int i = 0; i < n; i++) begin
      b = addr + 32'(i);
      k = ({b[31:2], 2'b00} == wa[0]) ? 0 : 1;
      be[k][b[1:0]] = 1'b1;
      wd[k][8*int'(b[1:0]) +: 8] = wdata[8*i +: 8];
    end
    nacc = (be[1] != 4'h0) ? 2 : 1;

    err = !legal;
    dur = 0;
    if (legal) begin
      for (int j = 0; j < nacc; j++) begin
        d = (j == 0) ? d0 : d1;
        dly_q.push_back(d);
        exp_acc_q.push_back({we, wa[j], be[j], we ? wd[j] : 32'h0});
        if (d >= NEVER) begin
          dur += TO + 1;
          err = 1'b1;
          break;
        end
        dur += d + 1;
        if (we)
          for (int i = 0; i < n; i++) begin
            b = addr + 32'(i);
            if ((({b[31:2], 2'b00} == wa[0]) ? 0 : 1) == j) ref_mem[b] = wdata[8*i +: 8];
          end
      end
    end

    val = 32'h0;
    for (int i = 0; i < n; i++) val[8*i +: 8] = ref_rd(addr + 32'(i));
    case (f3)
      3'b000:  rdata = {{24{val[7]}}, val[7:0]};
      3'b001:  rdata = {{16{val[15]}}, val[15:0]};
      3'b100:  rdata = {24'h0, val[7:0]};
      3'b101:  rdata = {16'h0, val[15:0]};
      default: rdata = val;
    endcase
    if (we || err) rdata = 32'h0;

    if (expect_resp) exp_q.push_back({32'(t + 32'(dur) + 1), err, rdata});

    @(negedge clk);
    req_valid  = 1'b0;
    req_addr   = $urandom();
    req_wdata  = $urandom();
    req_funct3 = 3'($urandom_range(0, 7));
  endtask

  // ---------------- memory responder (checks accesses) ----------------
  initial begin
    int          wait_cnt;
    bit          active;
    logic [68:0] ea;
    logic [31:0] w;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    active    = 1'b0;
    wait_cnt  = 0;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = $urandom();
      if (rst || !mem_req) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          active = 1'b1;
          if (exp_acc_q.size() == 0) begin
            check("unexpected_mem_access", {11'h0, mem_we, mem_addr, mem_be, mem_wdata}, 80'h0);
            wait_cnt = NEVER;
          end else begin
            ea = exp_acc_q.pop_front();
            check("mem_access", 80'({mem_we, mem_addr, mem_be, mem_we ? mem_wdata : 32'h0}), 80'(ea));
            wait_cnt = (dly_q.size() != 0) ? dly_q.pop_front() : NEVER;
          end
        end
        if (wait_cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = bus_rd(mem_addr);
          if (mem_we) begin
            w = bus_rd(mem_addr);
            for (int i = 0; i < 4; i++) if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
            bus_mem[mem_addr] = w;
          end
          active = 1'b0;
        end else if (wait_cnt < NEVER) begin
          wait_cnt--;
        end
      end
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {47'h0, resp_err, resp_rdata}, 80'h0);
        end else begin
          e = exp_q.pop_front();
          check("resp_data", 80'({resp_err, resp_rdata}), 80'(e[32:0]));
          check("resp_cycle", 80'(cyc + 1), 80'(e[64:33]));
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          d0, d1;

    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'h0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_ready", 80'(req_ready), 80'(1));
    check("reset_resp", 80'({resp_valid, resp_err, resp_rdata}), 80'h0);
    check("reset_mem", 80'({mem_req, mem_we, mem_addr, mem_be, mem_wdata}), 80'h0);
    rst = 1'b0;

    // directed cases
    issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 1);
    issue(1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 0, 0, 1);
    preload(32'h0000_0100, 32'h8012_3456);
    preload(32'h0000_0104, 32'h89AB_CD7F);
    issue(1'b0, 3'b001, 32'h0000_0103, 32'h0, 0, 0, 1);
    preload(32'h0000_0300, 32'h00F0_0000);
    issue(1'b0, 3'b000, 32'h0000_0302, 32'h0, 0, 0, 1);
    issue(1'b0, 3'b100, 32'h0000_0302, 32'h0, 2, 0, 1);
    issue(1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 0, 1);
    issue(1'b1, 3'b100, 32'h0000_0100, 32'h0, 0, 0, 1);
    issue(1'b0, 3'b010, 32'h0000_0180, 32'h0, NEVER, 0, 1);
    issue(1'b1, 3'b010, 32'h0000_01C2, 32'h1122_3344, 1, NEVER, 1);
    issue(1'b0, 3'b010, 32'h0000_01C0, 32'h0, 0, 0, 1);
    issue(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 1, 3, 1);
    issue(1'b1, 3'b010, 32'hFFFF_FFFD, 32'hCAFE_F00D, 0, 2, 1);
    issue(1'b0, 3'b101, 32'h0000_0001, 32'h0, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                           : 32'h0000_0100 + 32'($urandom_range(0, 63));
      d0   = ($urandom_range(0, 19) == 0) ? NEVER : $urandom_range(0, 3);
      d1   = ($urandom_range(0, 19) == 0) ? NEVER : $urandom_range(0, 3);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(we, f3, addr, $urandom(), d0, d1, 1);
    end

    // asynchronous reset while the first access is waiting for an ack
    issue(1'b0, 3'b010, 32'h0000_0140, 32'h0, NEVER, 0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_mem_req", 80'(mem_req), 80'(0));
    check("rst_mid_ready", 80'(req_ready), 80'(1));
    check("rst_mid_resp", 80'(resp_valid), 80'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 0, 1);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("resp_queue_drained", 80'(exp_q.size()), 80'(0));
    check("access_queue_drained", 80'(exp_acc_q.size()), 80'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
